// File: rtl/grid_frame_streamer.sv
// grid_frame_streamer: reads the solver's cells back through its read port and
// streams them as a framed byte sequence: header, iteration tag, cell data,
// then a checksum chosen so that every byte of the frame sums to zero mod 256.
//
// Handshake: a byte transfers on a rising clk edge where tx_valid and tx_ready
// are both high. Once tx_valid is raised, tx_valid and tx_data hold until that
// transfer happens; only abort or reset may withdraw a byte. tx_valid does not
// depend combinationally on tx_ready.
module grid_frame_streamer #(
    parameter int          NUM_CELLS = 64,
    parameter int          ADDR_W    = 6,
    parameter int          READ_LAT  = 2,
    parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        iter_nib,
    output logic [1:0]        sol_mode,
    output logic [ADDR_W-1:0] sol_addr,
    input  logic [7:0]        sol_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_TAG   = 3'd2;
    localparam logic [2:0] S_FETCH = 3'd3;
    localparam logic [2:0] S_SEND  = 3'd4;
    localparam logic [2:0] S_CSUM  = 3'd5;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_READ = 2'b10;

    localparam int LAT_W = $clog2(READ_LAT + 2);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LAT);
    localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(NUM_CELLS - 1);

    logic [2:0]        state;
    logic [3:0]        tag;
    logic [7:0]        acc;
    logic [ADDR_W-1:0] counter;
    logic [LAT_W-1:0]  lat_cnt;

    logic       accept;
    logic [7:0] acc_next;

    // Transfer strobe and the running sum including the byte now on the bus.
    always_comb begin
        accept   = tx_valid && tx_ready;
        acc_next = acc + tx_data;
    end

    // Frame sequencer: every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tag      <= 4'h0;
            acc      <= 8'h00;
            counter  <= '0;
            lat_cnt  <= '0;
            sol_mode <= MODE_RUN;
            sol_addr <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && busy) begin
                // Abort drops any byte in flight and releases the solver.
                state    <= S_IDLE;
                tx_valid <= 1'b0;
                sol_mode <= MODE_RUN;
                sol_addr <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // A start coinciding with the done pulse is ignored.
                        if (start && !done) begin
                            tag      <= iter_nib;
                            acc      <= 8'h00;
                            counter  <= '0;
                            busy     <= 1'b1;
                            sol_mode <= MODE_READ;
                            tx_data  <= HDR_BYTE;
                            tx_valid <= 1'b1;
                            state    <= S_HDR;
                        end
                    end
                    S_HDR: begin
                        if (accept) begin
                            acc     <= acc_next;
                            tx_data <= {4'h0, tag};
                            state   <= S_TAG;
                        end
                    end
                    S_TAG: begin
                        if (accept) begin
                            acc      <= acc_next;
                            tx_valid <= 1'b0;
                            sol_addr <= counter;
                            lat_cnt  <= '0;
                            state    <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        // Address has been stable since the first FETCH cycle;
                        // sample once the solver read latency has elapsed.
                        if (lat_cnt == LAT_LAST) begin
                            tx_data  <= sol_data;
                            tx_valid <= 1'b1;
                            state    <= S_SEND;
                        end else begin
                            lat_cnt <= lat_cnt + 1'b1;
                        end
                    end
                    S_SEND: begin
                        if (accept) begin
                            acc <= acc_next;
                            if (counter == CELL_LAST) begin
                                tx_data <= 8'h00 - acc_next;
                                state   <= S_CSUM;
                            end else begin
                                counter  <= counter + 1'b1;
                                sol_addr <= counter + 1'b1;
                                tx_valid <= 1'b0;
                                lat_cnt  <= '0;
                                state    <= S_FETCH;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (accept) begin
                            tx_valid <= 1'b0;
                            sol_mode <= MODE_RUN;
                            sol_addr <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        tx_valid <= 1'b0;
                        sol_mode <= MODE_RUN;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/grid_frame_streamer.md
Name: grid_frame_streamer

Overview:
Downstream readback stage for the 16x16 heat-equation solver core. On a start pulse it pauses the solver by driving read mode, walks the host-addressable cells, and captures each temperature byte. It emits the bytes as a framed byte stream over a valid/ready handshake: header, iteration tag, cell data, checksum. It feeds the chip's serial or parallel output shim and returns the solver to run mode when the frame completes.

Parameters:
NUM_CELLS, 64, cells read per frame, addresses 0..NUM_CELLS-1; must be ≤ 2^ADDR_W.
ADDR_W, 6, width of the solver address field.
READ_LAT, 2, cycles from address presented to solver data valid.
HDR_BYTE, 8'hA5, first byte of every frame.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to stream one frame; ignored while busy
abort  input  1  cancel the frame in progress
iter_nib  input  4  solver iteration_count[11:8] status nibble
sol_mode  output  2  mode field to the solver: 2'b00 = run, 2'b10 = read
sol_addr  output  ADDR_W  cell address to the solver
sol_data  input  8  solver read data
tx_data  output  8  stream byte
tx_valid  output  1  tx_data is valid
tx_ready  input  1  consumer accepts the byte when tx_valid and tx_ready are both high at a clock edge
busy  output  1  a frame is in progress
done  output  1  one-cycle pulse after the checksum byte is accepted

Behaviour:
- Reset (async assert, sync release): state IDLE, sol_mode=00, sol_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, checksum accumulator=0, cell counter=0.
- All outputs are registered.
- IDLE:
  - sol_mode=00 and busy=0.
  - start=1 at an edge: latch iter_nib, clear the accumulator and the cell counter, set busy=1 and sol_mode=10, go to HDR.
- HDR: tx_data=HDR_BYTE, tx_valid=1. On accept go to TAG.
- TAG: tx_data={4'h0, latched iter_nib}. On accept go to FETCH with sol_addr=counter.
- FETCH:
  - sol_addr is stable from the first FETCH cycle k.
  - sol_data is sampled at the edge ending cycle k+READ_LAT, i.e. READ_LAT+1 cycles in FETCH.
  - The sample is loaded into tx_data, tx_valid=1, go to SEND.
- SEND:
  - tx_data and tx_valid hold until accepted.
  - On accept: accumulator += byte (mod 256).
  - If counter==NUM_CELLS-1, go to CSUM. Otherwise increment counter, update sol_addr, go to FETCH.
- CSUM:
  - tx_data = (0 - (HDR_BYTE + tag + sum of data)) mod 256, so all frame bytes sum to 0 mod 256.
  - The accumulator includes header and tag bytes.
  - On accept: tx_valid=0, sol_mode=00, busy=0, done=1 for exactly one cycle, go to IDLE.
- Handshake rules:
  - tx_valid never deasserts and tx_data never changes before acceptance, except on abort or reset.
  - tx_valid=0 in FETCH.
  - At most one byte is accepted per cycle.
- Frame length is always NUM_CELLS+3 bytes; an accepted frame is never truncated except by abort or reset.
- abort=1 at any edge while busy:
  - Next state IDLE, tx_valid=0, sol_mode=00, busy=0, no done pulse.
  - A byte handshaking in the same cycle is considered dropped.
  - abort has priority over start; abort in IDLE has no effect.
- start while busy is ignored and not queued. start and the done pulse in the same cycle: start is ignored.
- The counter never exceeds NUM_CELLS-1; sol_addr wraps to 0 only by returning to IDLE.
- Reset mid-frame returns immediately to reset values, releasing the solver to run mode.

Test Plan:
- Host preloads cells 0..63 with value=address, iter_nib=4'h3, start, tx_ready always 1 → bytes A5, 03, 00..3F, then checksum. Total 67 bytes, modular sum 0. done pulses once; sol_mode returns to 00.
- Same frame with tx_ready toggling 1-of-3 cycles → identical byte sequence. tx_data stable while tx_valid=1 and tx_ready=0.
- Measure FETCH timing: sol_addr change to tx_valid rise is exactly READ_LAT+1 cycles, with a stub solver using 2-cycle registered read.
- abort asserted after the 10th data byte is accepted → tx_valid=0 and sol_mode=00 next cycle, no done. A following start yields a complete fresh frame starting A5.
- start pulsed during an active frame → no second frame, byte count stays 67. rst_n low mid-SEND → all outputs zero asynchronously.
- All cells 0xFF, iter_nib=0 → checksum = (0 - (A5 + 00 + 64·FF)) mod 256 = 0x9B.
